// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter with a multi-bit step checker.
// Define GRAY_TO_BINARY_PIPE_EN for a two-stage (latency 2) build; the default is latency 1.
module gray_to_binary #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray,
   output logic             out_valid,
   output logic [WIDTH-1:0] binary,
   output logic             step_err
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] last_gray;
   logic             have_last;
   logic [WIDTH-1:0] diff;

   assign diff = gray ^ last_gray;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gray <= '0;
         have_last <= 1'b0;
      end else if (in_valid) begin
         last_gray <= gray;
         have_last <= 1'b1;
      end
   end

`ifdef GRAY_TO_BINARY_PIPE_EN

   localparam int H = WIDTH / 2;

   logic             s1_valid;
   logic [WIDTH-1:H] s1_upper;
   logic [H-1:0]     s1_low;
   logic [WIDTH-1:0] s1_diff;
   logic             s1_have;
   logic [WIDTH-1:H] upper_bin;
   logic [H-1:0]     low_bin;
   logic             multi;

   always_comb begin
      upper_bin            = '0;
      upper_bin[WIDTH-1]   = gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= H; i--)
         upper_bin[i] = upper_bin[i+1] ^ gray[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_upper <= '0;
         s1_low   <= '0;
         s1_diff  <= '0;
         s1_have  <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_upper <= upper_bin;
            s1_low   <= gray[H-1:0];
            s1_diff  <= diff;
            s1_have  <= have_last;
         end
      end
   end

   // Lower half continues the prefix XOR from the lowest resolved upper bit.
   always_comb begin
      low_bin        = '0;
      low_bin[H-1]   = s1_upper[H] ^ s1_low[H-1];
      for (int i = H - 2; i >= 0; i--)
         low_bin[i] = low_bin[i+1] ^ s1_low[i];
   end

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi = s1_have && (|(s1_diff & (s1_diff - ONE)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         binary    <= '0;
         step_err  <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            binary   <= {s1_upper, low_bin};
            step_err <= multi;
         end
      end
   end

`else

   logic [WIDTH-1:0] bin_comb;
   logic             multi;

   always_comb begin
      bin_comb          = '0;
      bin_comb[WIDTH-1] = gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--)
         bin_comb[i] = bin_comb[i+1] ^ gray[i];
   end

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi = have_last && (|(diff & (diff - ONE)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         binary    <= '0;
         step_err  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            binary   <= bin_comb;
            step_err <= multi;
         end
      end
   end

`endif

endmodule

// File: tb/tb_gray_to_binary.sv
// Directed self-checking bench for gray_to_binary (WIDTH=8), either latency build.
module tb_gray_to_binary;

`ifdef GRAY_TO_BINARY_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] gray = 8'h00;
   logic       out_valid;
   logic [7:0] binary;
   logic       step_err;

   int checks = 0;
   int failures = 0;

   gray_to_binary #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .gray      (gray),
      .out_valid (out_valid),
      .binary    (binary),
      .step_err  (step_err)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      gray = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (binary !== 8'h00) begin
         failures++; $display("FAIL reset_binary: got %h expected 00", binary);
      end
      checks++;
      if (step_err !== 1'b0) begin
         failures++; $display("FAIL reset_step_err: got %b expected 0", step_err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_known_vectors();
      logic [7:0] g [0:6];
      logic [7:0] b [0:6];
      logic       e [0:6];
      g = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'hAA, 8'hFF};
      b = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0A, 8'hCC, 8'hAA};
      e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int n = 0; n < 7 + LAT; n++) begin
         @(negedge clk);
         if (n >= LAT) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++; $display("FAIL known_valid[%0d]: got %b expected 1", n - LAT, out_valid);
            end
            checks++;
            if (binary !== b[n-LAT]) begin
               failures++; $display("FAIL known_binary[%0d]: got %h expected %h", n - LAT, binary, b[n-LAT]);
            end
            checks++;
            if (step_err !== e[n-LAT]) begin
               failures++; $display("FAIL known_step_err[%0d]: got %b expected %b", n - LAT, step_err, e[n-LAT]);
            end
         end
         if (n < 7) begin
            in_valid = 1'b1;
            gray = g[n];
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] nb;
      logic [7:0] exp_b;
      do_reset();
      for (int n = 0; n < 257 + LAT; n++) begin
         @(negedge clk);
         if (n >= LAT) begin
            exp_b = 8'((n - LAT) % 256);
            checks++;
            if (out_valid !== 1'b1 || binary !== exp_b || step_err !== 1'b0) begin
               failures++;
               $display("FAIL sweep[%0d]: got valid=%b bin=%h err=%b expected valid=1 bin=%h err=0",
                        n - LAT, out_valid, binary, step_err, exp_b);
            end
         end
         if (n < 257) begin
            nb = 8'(n % 256);
            in_valid = 1'b1;
            gray = nb ^ (nb >> 1);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_bubbles();
      logic       v  [0:3];
      logic [7:0] g  [0:3];
      logic [7:0] b  [0:3];
      v = '{1'b1, 1'b0, 1'b0, 1'b1};
      g = '{8'h03, 8'h00, 8'h00, 8'h02};
      b = '{8'h02, 8'h02, 8'h02, 8'h03};
      do_reset();
      for (int n = 0; n < 4 + LAT; n++) begin
         @(negedge clk);
         if (n >= LAT) begin
            checks++;
            if (out_valid !== v[n-LAT]) begin
               failures++; $display("FAIL bubble_valid[%0d]: got %b expected %b", n - LAT, out_valid, v[n-LAT]);
            end
            checks++;
            if (binary !== b[n-LAT]) begin
               failures++; $display("FAIL bubble_binary[%0d]: got %h expected %h", n - LAT, binary, b[n-LAT]);
            end
            checks++;
            if (step_err !== 1'b0) begin
               failures++; $display("FAIL bubble_step_err[%0d]: got %b expected 0", n - LAT, step_err);
            end
         end
         if (n < 4) begin
            in_valid = v[n];
            gray = g[n];
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] pre_b;
      pre_b = (LAT == 1) ? 8'h0B : 8'h0A;
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      gray = 8'h0F;
      @(negedge clk);
      gray = 8'h0E;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      checks++;
      if (binary !== pre_b) begin
         failures++; $display("FAIL async_pre_binary: got %h expected %h", binary, pre_b);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (binary !== 8'h00 || out_valid !== 1'b0 || step_err !== 1'b0) begin
         failures++;
         $display("FAIL async_clear: got valid=%b bin=%h err=%b expected valid=0 bin=00 err=0",
                  out_valid, binary, step_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      gray = 8'hFF;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (k < LAT) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++; $display("FAIL async_flushed[%0d]: got valid=%b expected 0", k, out_valid);
            end
         end else begin
            checks++;
            if (out_valid !== 1'b1 || binary !== 8'hAA || step_err !== 1'b0) begin
               failures++;
               $display("FAIL async_first_word: got valid=%b bin=%h err=%b expected valid=1 bin=aa err=0",
                        out_valid, binary, step_err);
            end
         end
      end
   endtask

   task automatic test_repeat();
      do_reset();
      // prefix XOR of 01010101 is 01100110
      for (int n = 0; n < 2 + LAT; n++) begin
         @(negedge clk);
         if (n >= LAT) begin
            checks++;
            if (out_valid !== 1'b1 || binary !== 8'h66 || step_err !== 1'b0) begin
               failures++;
               $display("FAIL repeat[%0d]: got valid=%b bin=%h err=%b expected valid=1 bin=66 err=0",
                        n - LAT, out_valid, binary, step_err);
            end
         end
         in_valid = (n < 2);
         gray = 8'h55;
      end
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_sweep();
      test_bubbles();
      test_async_reset();
      test_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
